// File: rtl/reg_bus_arbiter_if.sv
// rtl/reg_bus_arbiter_if.sv - master A/B command ports and shared register bus for reg_bus_arbiter
// slave modport is the arbiter side; master modport is the side driving requests and bus_rdata.
interface reg_bus_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              a_req;
  logic              a_lock;
  logic              a_wen;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_done;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_lock;
  logic              b_wen;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_done;
  logic [DATA_W-1:0] b_rdata;

  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_wen;
  logic [DATA_W-1:0] bus_rdata;
  logic [1:0]        owner;

  modport slave (
    input  a_req, a_lock, a_wen, a_addr, a_wdata,
    input  b_req, b_lock, b_wen, b_addr, b_wdata,
    input  bus_rdata,
    output a_gnt, a_done, a_rdata,
    output b_gnt, b_done, b_rdata,
    output bus_addr, bus_wdata, bus_wen, owner
  );

  modport master (
    output a_req, a_lock, a_wen, a_addr, a_wdata,
    output b_req, b_lock, b_wen, b_addr, b_wdata,
    output bus_rdata,
    input  a_gnt, a_done, a_rdata,
    input  b_gnt, b_done, b_rdata,
    input  bus_addr, bus_wdata, bus_wen, owner
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - two-master register bus arbiter, fixed priority to A, lockable ownership
// Optional B starvation guard enabled by defining REG_ARB_STARVE_GUARD_EN.
module reg_bus_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
`ifdef REG_ARB_STARVE_GUARD_EN
  , parameter int STARVE_MAX = 4
`endif
) (
  input logic              sysclk,
  input logic              reset,
  reg_bus_arbiter_if.slave rb
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WR    = 2'd1;
  localparam logic [1:0] ST_RD    = 2'd2;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_A    = 2'b01;
  localparam logic [1:0] OWN_B    = 2'b10;
  localparam logic [2:0] RD_LAST  = 3'(RD_LAT - 1);

  logic [1:0]        state;
  logic [2:0]        rd_cnt;
  logic              cur_b;
  logic              cur_lock;
  logic              locked;
  logic              lock_b;
  logic [3:0]        idle_cnt;
  logic              sel_a;
  logic              sel_b;
  logic              force_b;
  logic              finish;
  logic              sel_wen;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef REG_ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt;

  // Saturating count of A grants taken while B was waiting.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 3'd0;
    end else if (!rb.b_req || sel_b) begin
      starve_cnt <= 3'd0;
    end else if (sel_a && (starve_cnt < 3'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  assign force_b = rb.b_req && (starve_cnt >= 3'(STARVE_MAX));
`else
  assign force_b = 1'b0;
`endif

  always_comb begin
    sel_a = 1'b0;
    sel_b = 1'b0;
    if (state == ST_IDLE) begin
      if (locked) begin
        sel_a = !lock_b && rb.a_req;
        sel_b = lock_b && rb.b_req;
      end else if (force_b) begin
        sel_b = 1'b1;
      end else if (rb.a_req) begin
        sel_a = 1'b1;
      end else if (rb.b_req) begin
        sel_b = 1'b1;
      end
    end
    sel_wen   = sel_b ? rb.b_wen   : rb.a_wen;
    sel_lock  = sel_b ? rb.b_lock  : rb.a_lock;
    sel_addr  = sel_b ? rb.b_addr  : rb.a_addr;
    sel_wdata = sel_b ? rb.b_wdata : rb.a_wdata;
    finish    = (state == ST_WR) || ((state == ST_RD) && (rd_cnt == RD_LAST));
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      rd_cnt       <= 3'd0;
      cur_b        <= 1'b0;
      cur_lock     <= 1'b0;
      locked       <= 1'b0;
      lock_b       <= 1'b0;
      idle_cnt     <= 4'd0;
      rb.a_gnt     <= 1'b0;
      rb.b_gnt     <= 1'b0;
      rb.a_done    <= 1'b0;
      rb.b_done    <= 1'b0;
      rb.a_rdata   <= '0;
      rb.b_rdata   <= '0;
      rb.bus_addr  <= '0;
      rb.bus_wdata <= '0;
      rb.bus_wen   <= 1'b0;
      rb.owner     <= OWN_NONE;
    end else begin
      rb.a_gnt   <= sel_a;
      rb.b_gnt   <= sel_b;
      rb.a_done  <= finish && !cur_b;
      rb.b_done  <= finish && cur_b;
      rb.bus_wen <= (sel_a || sel_b) && sel_wen;
      if (sel_a || sel_b) begin
        rb.bus_addr  <= sel_addr;
        rb.bus_wdata <= sel_wdata;
        rb.owner     <= sel_b ? OWN_B : OWN_A;
        cur_b        <= sel_b;
        cur_lock     <= sel_lock;
        rd_cnt       <= 3'd0;
        idle_cnt     <= 4'd0;
        state        <= sel_wen ? ST_WR : ST_RD;
      end else if (finish) begin
        // The lock flag of the finishing transaction decides who owns the bus next.
        state    <= ST_IDLE;
        locked   <= cur_lock;
        lock_b   <= cur_b;
        rb.owner <= !cur_lock ? OWN_NONE : (cur_b ? OWN_B : OWN_A);
        if (state == ST_RD) begin
          if (cur_b) begin
            rb.b_rdata <= rb.bus_rdata;
          end else begin
            rb.a_rdata <= rb.bus_rdata;
          end
        end
      end else if (state == ST_RD) begin
        rd_cnt <= rd_cnt + 3'd1;
      end else if (locked) begin
        // An idle lock owner loses the bus after 16 idle cycles.
        if (idle_cnt == 4'd15) begin
          locked   <= 1'b0;
          rb.owner <= OWN_NONE;
          idle_cnt <= 4'd0;
        end else begin
          idle_cnt <= idle_cnt + 4'd1;
        end
      end
    end
  end
endmodule
